// File: rtl/ex_stage_if.sv
// Pipeline-facing signals of the execute stage: ID/EX bundle in, EX/MEM bundle out,
// plus the flush request and the busy stall back to hazard logic.
interface ex_stage_if;
  logic [98:0] id_ex;
  logic        in_valid;
  logic        flush;
  logic        busy;
  logic [58:0] ex_mem;
  logic        out_valid;

  modport master (
    output id_ex, in_valid, flush,
    input  busy, ex_mem, out_valid
  );

  modport slave (
    input  id_ex, in_valid, flush,
    output busy, ex_mem, out_valid
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: 8-bit ALU, branch target adder and an iterative 8-step shift-add
// multiplier that stalls upstream via busy while it runs.
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  typedef enum logic {IDLE, MUL} state_e;

  state_e      state_q, state_d;
  logic [58:0] ex_mem_q, ex_mem_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  acc_q, acc_d;
  logic [98:0] bundle_q, bundle_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  acc_step;

  function automatic logic [7:0] operand_b(input logic [98:0] b);
    return b[7] ? b[64:57] : b[56:49];
  endfunction

  function automatic logic is_mult(input logic [98:0] b);
    return (b[5:4] == 2'b10) && (b[62:57] == 6'h18);
  endfunction

  // MULT is never routed through here; the iterative datapath supplies its result.
  function automatic logic [7:0] alu(input logic [98:0] b);
    logic [7:0] a;
    logic [7:0] op;
    a  = b[48:41];
    op = operand_b(b);
    case (b[5:4])
      2'b01:   return a - op;
      2'b10: begin
        case (b[62:57])
          6'h20:   return a + op;
          6'h22:   return a - op;
          6'h24:   return a & op;
          6'h25:   return a | op;
          6'h2A:   return ($signed(a) < $signed(op)) ? 8'h01 : 8'h00;
          default: return 8'h00;
        endcase
      end
      default: return a + op;
    endcase
  endfunction

  function automatic logic [58:0] pack(input logic [98:0] b, input logic [7:0] res);
    logic [58:0] r;
    r[0]     = b[8];
    r[1]     = b[3];
    r[2]     = b[2];
    r[3]     = b[6];
    r[4]     = b[1];
    r[5]     = (res == 8'h00);
    r[37:6]  = b[40:9] + {b[86:57], 2'b00};
    r[45:38] = res;
    r[53:46] = b[56:49];
    r[58:54] = b[0] ? b[98:94] : b[93:89];
    return r;
  endfunction

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d     = state_q;
    ex_mem_d    = ex_mem_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    count_d     = count_q;
    acc_d       = acc_q;
    bundle_d    = bundle_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.in_valid) begin
          if (is_mult(bus.id_ex)) begin
            bundle_d = bus.id_ex;
            mcand_d  = bus.id_ex[48:41];
            mplier_d = operand_b(bus.id_ex);
            acc_d    = 8'h00;
            count_d  = 4'd0;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            ex_mem_d    = pack(bus.id_ex, alu(bus.id_ex));
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        // Only the low product byte is kept, so 8-bit shifts and adds suffice.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 4'd1;
        if (count_q == 4'd7) begin
          ex_mem_d    = pack(bundle_q, acc_step);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d     = IDLE;
      ex_mem_d    = ex_mem_q;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ex_mem_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= 4'd0;
      acc_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      ex_mem_q    <= ex_mem_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
    end
  end

  // NOTE: operand/bundle latches are pure datapath, always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    bundle_q <= bundle_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign bus.ex_mem    = ex_mem_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push hand-computed EX/MEM bundles,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_ex_stage;

  localparam logic [8:0] C_RD   = 9'h001;
  localparam logic [8:0] C_BR   = 9'h002;
  localparam logic [8:0] C_MR   = 9'h004;
  localparam logic [8:0] C_M2R  = 9'h008;
  localparam logic [8:0] C_OP01 = 9'h010;
  localparam logic [8:0] C_OP10 = 9'h020;
  localparam logic [8:0] C_OP11 = 9'h030;
  localparam logic [8:0] C_MW   = 9'h040;
  localparam logic [8:0] C_SRC  = 9'h080;
  localparam logic [8:0] C_RW   = 9'h100;
  localparam logic [8:0] C_R    = C_RW | C_OP10 | C_RD;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [58:0] exp_q[$];
  logic [58:0] last_exp;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [98:0] mk_idex(input logic [8:0] ctrl, input logic [31:0] pc,
                                          input logic [7:0] rs, input logic [7:0] rt,
                                          input logic [31:0] imm, input logic [4:0] rt_a,
                                          input logic [4:0] rd_a);
    return {rd_a, rt_a, imm, rt, rs, pc, ctrl};
  endfunction

  function automatic logic [58:0] mk_exmem(input logic rw, input logic m2r, input logic mr,
                                           input logic mw, input logic br, input logic z,
                                           input logic [31:0] tgt, input logic [7:0] res,
                                           input logic [7:0] st, input logic [4:0] dest);
    return {dest, st, res, tgt, z, br, mw, mr, m2r, rw};
  endfunction

  // Monitor: every valid EX/MEM bundle must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          check("ex_mem", {5'd0, bus.ex_mem}, {5'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic send(input logic [98:0] b, input logic [58:0] e);
    bus.id_ex    = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("out_valid_1cyc", {63'd0, bus.out_valid}, 64'd1);
    check("busy_alu", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic send_mul(input logic [98:0] b, input logic [58:0] e);
    bus.id_ex    = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mul_busy_%0d", k), {63'd0, bus.busy}, 64'd1);
      check($sformatf("mul_bubble_%0d", k), {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    check("mul_done_busy", {63'd0, bus.busy}, 64'd0);
    check("mul_done_valid", {63'd0, bus.out_valid}, 64'd1);
  endtask

  // R-type table: pc=0 so branch_target = funct << 2.
  typedef struct {
    logic [7:0]  rs;
    logic [7:0]  rt;
    logic [7:0]  funct;
    logic [7:0]  res;
    logic [31:0] tgt;
  } rvec_t;

  rvec_t rtab[6] = '{
    '{8'h05, 8'h05, 8'h22, 8'h00, 32'h88},
    '{8'hF0, 8'h3C, 8'h24, 8'h30, 32'h90},
    '{8'hF0, 8'h3C, 8'h25, 8'hFC, 32'h94},
    '{8'hF0, 8'h3C, 8'h27, 8'h00, 32'h9C},
    '{8'h00, 8'h01, 8'h22, 8'hFF, 32'h88},
    '{8'h01, 8'h80, 8'h2A, 8'h00, 32'hA8}
  };

  initial begin
    checks       = 0;
    failures     = 0;
    last_exp     = '0;
    rst          = 1'b1;
    bus.id_ex    = '0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_mem", {5'd0, bus.ex_mem}, 64'd0);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
    end

    send(mk_idex(C_R, 32'h40, 8'hF0, 8'h20, 32'h20, 5'd3, 5'd5),
         mk_exmem(1, 0, 0, 0, 0, 0, 32'hC0, 8'h10, 8'h20, 5'd5));
    send(mk_idex(C_BR | C_OP01, 32'h100, 8'h33, 8'h33, 32'hFFFFFFFE, 5'd7, 5'd12),
         mk_exmem(0, 0, 0, 0, 1, 1, 32'hF8, 8'h00, 8'h33, 5'd7));
    send(mk_idex(C_R, 32'h200, 8'h80, 8'h01, 32'h2A, 5'd2, 5'd9),
         mk_exmem(1, 0, 0, 0, 0, 0, 32'h2A8, 8'h01, 8'h01, 5'd9));
    send(mk_idex(C_R | C_SRC, 32'h200, 8'h30, 8'h7F, 32'h2A, 5'd2, 5'd9),
         mk_exmem(1, 0, 0, 0, 0, 1, 32'h2A8, 8'h00, 8'h7F, 5'd9));
    send(mk_idex(C_RW | C_SRC | C_M2R | C_MR, 32'h10, 8'h01, 8'h55, 32'h7F, 5'd4, 5'd11),
         mk_exmem(1, 1, 1, 0, 0, 0, 32'h20C, 8'h80, 8'h55, 5'd4));
    send(mk_idex(C_SRC | C_MW, 32'h20, 8'hFF, 8'hAA, 32'hFFFFFFFF, 5'd6, 5'd13),
         mk_exmem(0, 0, 0, 1, 0, 0, 32'h1C, 8'hFE, 8'hAA, 5'd6));
    send(mk_idex(C_RW | C_OP11, 32'h0, 8'h7F, 8'h01, 32'h0, 5'd8, 5'd14),
         mk_exmem(1, 0, 0, 0, 0, 0, 32'h0, 8'h80, 8'h01, 5'd8));
    foreach (rtab[i]) begin
      send(mk_idex(C_R, 32'h0, rtab[i].rs, rtab[i].rt, {24'd0, rtab[i].funct}, 5'd2, 5'd1),
           mk_exmem(1, 0, 0, 0, 0, rtab[i].res == 8'h00, rtab[i].tgt, rtab[i].res,
                    rtab[i].rt, 5'd1));
    end

    @(posedge clk); #1;
    check("hold_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("hold_ex_mem", {5'd0, bus.ex_mem}, {5'd0, last_exp});

    // Back-to-back multiplies, the later ones accepted right after busy falls.
    send_mul(mk_idex(C_R, 32'h0, 8'h0D, 8'h0B, 32'h18, 5'd2, 5'd3),
             mk_exmem(1, 0, 0, 0, 0, 0, 32'h60, 8'h8F, 8'h0B, 5'd3));
    send_mul(mk_idex(C_R, 32'h0, 8'hFF, 8'hFF, 32'h18, 5'd2, 5'd3),
             mk_exmem(1, 0, 0, 0, 0, 0, 32'h60, 8'h01, 8'hFF, 5'd3));
    send_mul(mk_idex(C_R | C_SRC, 32'h0, 8'h10, 8'h03, 32'h18, 5'd2, 5'd3),
             mk_exmem(1, 0, 0, 0, 0, 0, 32'h60, 8'h80, 8'h03, 5'd3));
    send_mul(mk_idex(C_R, 32'h0, 8'h10, 8'h10, 32'h18, 5'd2, 5'd3),
             mk_exmem(1, 0, 0, 0, 0, 1, 32'h60, 8'h00, 8'h10, 5'd3));

    // Flush on the 4th MUL edge discards the multiply.
    bus.id_ex    = mk_idex(C_R, 32'h0, 8'h0D, 8'h0B, 32'h18, 5'd2, 5'd3);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flush_mul_started", {63'd0, bus.busy}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    send(mk_idex(C_R, 32'h40, 8'h12, 8'h34, 32'h20, 5'd3, 5'd7),
         mk_exmem(1, 0, 0, 0, 0, 0, 32'hC0, 8'h46, 8'h34, 5'd7));
    repeat (10) @(posedge clk);
    #1;
    check("flush_no_late_result", {63'd0, bus.out_valid}, 64'd0);

    // Flush coinciding with MULT acceptance: the multiply never starts.
    bus.id_ex    = mk_idex(C_R, 32'h0, 8'h0D, 8'h0B, 32'h18, 5'd2, 5'd3);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_accept_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_accept_valid", {63'd0, bus.out_valid}, 64'd0);

    // Reset in the middle of a multiply.
    bus.id_ex    = mk_idex(C_R, 32'h0, 8'h0D, 8'h0B, 32'h18, 5'd2, 5'd3);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midmul_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("midmul_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midmul_rst_ex_mem", {5'd0, bus.ex_mem}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("midmul_rst_no_result", {63'd0, bus.out_valid}, 64'd0);

    send(mk_idex(C_R, 32'h0, 8'h0F, 8'hF0, 32'h25, 5'd2, 5'd1),
         mk_exmem(1, 0, 0, 0, 0, 0, 32'h94, 8'hFF, 8'hF0, 5'd1));
    @(posedge clk); #1;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
